any1_memsm: RTL and testbench

//  Memory-access sequencer sitting downstream of the address generator: consumes the registered

---
 rtl/any1_pkg.sv | 19 +
 rtl/any1_mem_align.sv | 39 +++
 rtl/any1_memsm.sv | 226 ++++++++++++++++++++++
 tb/tb_any1_memsm.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/any1_pkg.sv
// Shared types for the any1 memory-access sequencer.
package any1_pkg;

  typedef enum logic [1:0] {
    Byte  = 2'd0,
    Wyde  = 2'd1,
    Tetra = 2'd2,
    Octa  = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    StIdle,
    StAgen,
    StAcc1,
    StAcc2,
    StFin
  } memsm_state_e;

endpackage

// File: rtl/any1_mem_align.sv
// Byte-lane alignment: lane mask and store shift for a given offset, and load shift plus
// sign/zero extension of the returned 128-bit window.
module any1_mem_align
  import any1_pkg::*;
(
  input  mem_size_e    sz,
  input  logic [2:0]   ofs,
  input  logic         sx,
  input  logic [63:0]  st_dat,
  input  logic [127:0] ld_dat,
  output logic [15:0]  mask,
  output logic [127:0] st_data,
  output logic [63:0]  ld_res
);

  logic [63:0] shifted;

  always_comb begin
    unique case (sz)
      Byte:    mask = 16'h0001 << ofs;
      Wyde:    mask = 16'h0003 << ofs;
      Tetra:   mask = 16'h000f << ofs;
      default: mask = 16'h00ff << ofs;
    endcase
  end

  assign st_data = {64'd0, st_dat} << {ofs, 3'b000};
  assign shifted = 64'(ld_dat >> {ofs, 3'b000});

  always_comb begin
    unique case (sz)
      Byte:    ld_res = {{56{sx & shifted[7]}}, shifted[7:0]};
      Wyde:    ld_res = {{48{sx & shifted[15]}}, shifted[15:0]};
      Tetra:   ld_res = {{32{sx & shifted[31]}}, shifted[31:0]};
      default: ld_res = shifted;
    endcase
  end

endmodule

// File: rtl/any1_memsm.sv
// Memory-access sequencer: runs one or two bus cycles per element, returns aligned load data
// and steps the agen through vector elements.
module any1_memsm
  import any1_pkg::*;
#(
  parameter int unsigned AWID = 32,
  parameter int unsigned TMO  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  output logic            rdy_o,
  input  logic            we_i,
  input  logic [1:0]      sz_i,
  input  logic            sx_i,
  input  logic [63:0]     dat_i,
  input  logic [5:0]      vl_i,
  input  logic [AWID-1:0] ea_i,
  output logic [5:0]      step_o,
  output logic            done_o,
  output logic            last_o,
  output logic [63:0]     res_o,
  output logic            err_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [7:0]      sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [63:0]     dat_o,
  input  logic            ack_i,
  input  logic            berr_i,
  input  logic [63:0]     dat_bi
);

  localparam int unsigned TW = $clog2(TMO + 1);

  memsm_state_e    state_q, state_d;
  logic            we_q, we_d, sx_q, sx_d;
  mem_size_e       sz_q, sz_d;
  logic [63:0]     dat_q, dat_d;
  logic [5:0]      vl_q, vl_d, step_q, step_d;
  logic [2:0]      ofs_q, ofs_d;
  logic            split_q, split_d;
  logic [7:0]      sel_hi_q, sel_hi_d;
  logic [63:0]     dat_hi_q, dat_hi_d;
  logic [63:0]     lo_q, lo_d, hi_q, hi_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, bwe_q, bwe_d;
  logic [7:0]      sel_q, sel_d;
  logic [AWID-1:0] adr_q, adr_d;
  logic [63:0]     bdat_q, bdat_d;

  logic [2:0]      align_ofs;
  logic [15:0]     mask;
  logic [127:0]    st_data;
  logic [63:0]     ld_res;
  logic            last;
  logic            timeout;

  // Offset comes straight from the agen while computing lanes, from the latch afterwards.
  assign align_ofs = (state_q == StAgen) ? ea_i[2:0] : ofs_q;

  any1_mem_align u_align (
    .sz      (sz_q),
    .ofs     (align_ofs),
    .sx      (sx_q),
    .st_dat  (dat_q),
    .ld_dat  ({hi_q, lo_q}),
    .mask    (mask),
    .st_data (st_data),
    .ld_res  (ld_res)
  );

  // vl of 0 compares like 1, so no special case is needed.
  assign last    = err_q || (({1'b0, step_q} + 7'd1) >= {1'b0, vl_q});
  assign timeout = !ack_i && (tmo_q == TW'(TMO - 1));

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    sx_d     = sx_q;
    sz_d     = sz_q;
    dat_d    = dat_q;
    vl_d     = vl_q;
    step_d   = step_q;
    ofs_d    = ofs_q;
    split_d  = split_q;
    sel_hi_d = sel_hi_q;
    dat_hi_d = dat_hi_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    bwe_d    = bwe_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    bdat_d   = bdat_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d    = we_i;
          sz_d    = mem_size_e'(sz_i);
          sx_d    = sx_i;
          dat_d   = dat_i;
          vl_d    = vl_i;
          step_d  = 6'd0;
          err_d   = 1'b0;
          state_d = StAgen;
        end
      end
      StAgen: begin
        ofs_d    = ea_i[2:0];
        split_d  = |mask[15:8];
        sel_hi_d = mask[15:8];
        dat_hi_d = st_data[127:64];
        cyc_d    = 1'b1;
        stb_d    = 1'b1;
        bwe_d    = we_q;
        adr_d    = {ea_i[AWID-1:3], 3'b000};
        sel_d    = mask[7:0];
        bdat_d   = st_data[63:0];
        tmo_d    = '0;
        state_d  = StAcc1;
      end
      StAcc1, StAcc2: begin
        if (berr_i || timeout) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = StFin;
        end else if (ack_i) begin
          if (state_q == StAcc1) lo_d = dat_bi;
          else hi_d = dat_bi;
          if (state_q == StAcc1 && split_q) begin
            adr_d   = adr_q + AWID'(8);
            sel_d   = sel_hi_q;
            bdat_d  = dat_hi_q;
            tmo_d   = '0;
            state_d = StAcc2;
          end else begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = StFin;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StFin: begin
        err_d = 1'b0;
        if (last) begin
          state_d = StIdle;
        end else begin
          step_d  = step_q + 6'd1;
          state_d = StAgen;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      sx_q     <= 1'b0;
      sz_q     <= Byte;
      dat_q    <= '0;
      vl_q     <= '0;
      step_q   <= '0;
      ofs_q    <= '0;
      split_q  <= 1'b0;
      sel_hi_q <= '0;
      dat_hi_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      bwe_q    <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      bdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      sx_q     <= sx_d;
      sz_q     <= sz_d;
      dat_q    <= dat_d;
      vl_q     <= vl_d;
      step_q   <= step_d;
      ofs_q    <= ofs_d;
      split_q  <= split_d;
      sel_hi_q <= sel_hi_d;
      dat_hi_q <= dat_hi_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      bwe_q    <= bwe_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      bdat_q   <= bdat_d;
    end
  end

  assign rdy_o  = (state_q == StIdle);
  assign step_o = step_q;
  assign done_o = (state_q == StFin);
  assign last_o = done_o && last;
  assign err_o  = done_o && err_q;
  assign res_o  = (done_o && !we_q && !err_q) ? ld_res : 64'd0;
  assign cyc_o  = cyc_q;
  assign stb_o  = stb_q;
  assign we_o   = bwe_q;
  assign sel_o  = sel_q;
  assign adr_o  = adr_q;
  assign dat_o  = bdat_q;

endmodule

// File: tb/tb_any1_memsm.sv
// Bench for any1_memsm: byte-array bus slave, directed vector table, hand-written corner
// sequences and randomized ops scored against a byte-level memory model.
module tb_any1_memsm;

  localparam int unsigned AWID = 32;
  localparam int unsigned TMO  = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we_in = 1'b0, sx_in = 1'b0;
  logic [1:0]  sz_in = 2'd0;
  logic [63:0] dat_in = 64'd0;
  logic [5:0]  vl_in = 6'd0;
  logic [31:0] ea, cur_base = 32'd0, cur_stride = 32'd0;
  logic        rdy, done, last, err, cyc, stb, bwe;
  logic [5:0]  step;
  logic [63:0] res, bdout;
  logic [7:0]  sel;
  logic [31:0] adr;
  logic        ack = 1'b0, berr = 1'b0;
  logic [63:0] dat_bi = 64'd0;

  always #5 clk = ~clk;

  assign ea = cur_base + cur_stride * {26'd0, step};

  any1_memsm #(.AWID(AWID), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .rdy_o(rdy), .we_i(we_in), .sz_i(sz_in), .sx_i(sx_in),
    .dat_i(dat_in), .vl_i(vl_in), .ea_i(ea), .step_o(step), .done_o(done), .last_o(last),
    .res_o(res), .err_o(err), .cyc_o(cyc), .stb_o(stb), .we_o(bwe), .sel_o(sel), .adr_o(adr),
    .dat_o(bdout), .ack_i(ack), .berr_i(berr), .dat_bi(dat_bi)
  );

  int tests = 0;
  int fails = 0;

  // Bus slave: 256-byte memory window, random wait states, optional berr on a given ack.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       mem_load = 1'b0;
  logic       slave_silent = 1'b0;
  int         wait_max = 0;
  int         wait_cnt = 0;
  int         ack_total = 0;
  int         berr_at = 0;

  always @(negedge clk) begin
    logic [63:0] rd;
    logic [7:0]  idx;
    ack  <= 1'b0;
    berr <= 1'b0;
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (!rst && cyc && stb && !slave_silent) begin
      if (wait_cnt != 0) begin
        wait_cnt <= wait_cnt - 1;
      end else begin
        ack       <= 1'b1;
        ack_total <= ack_total + 1;
        for (int k = 0; k < 8; k++) begin
          idx = adr[7:0] + 8'(k);
          rd[8*k +: 8] = mem[idx];
          if (bwe && sel[k] && (ack_total + 1 != berr_at)) mem[idx] <= bdout[8*k +: 8];
        end
        if (ack_total + 1 == berr_at) berr <= 1'b1;
        dat_bi   <= rd;
        wait_cnt <= $urandom_range(wait_max, 0);
      end
    end
  end

  // Monitor: done records plus first/second bus-cycle capture of the latest op.
  typedef struct {
    logic [63:0] res;
    logic        last;
    logic        err;
    logic [5:0]  step;
    logic        cyc;
  } done_t;
  done_t       dq[$];
  int          cyc_total = 0;
  logic        prev_cyc = 1'b0;
  logic [31:0] prev_adr = 32'd0, first_adr = 32'd0, sec_adr = 32'd0;
  logic [7:0]  first_sel = 8'd0, sec_sel = 8'd0;
  logic [63:0] first_dat = 64'd0, sec_dat = 64'd0;

  always @(negedge clk) begin
    if (done) dq.push_back('{res, last, err, step, cyc});
    if (cyc) cyc_total <= cyc_total + 1;
    if (cyc && !prev_cyc) begin
      first_adr <= adr;
      first_sel <= sel;
      first_dat <= bdout;
    end else if (cyc && prev_cyc && adr != prev_adr) begin
      sec_adr <= adr;
      sec_sel <= sel;
      sec_dat <= bdout;
    end
    prev_cyc <= cyc;
    prev_adr <= adr;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk);
    #1 mem_load = 1'b1;
    @(negedge clk);
    #1 mem_load = 1'b0;
  endtask

  // Issue one op; lat = negedges from acceptance to first done, span = negedges until idle.
  task automatic run_op(input logic w, input logic [1:0] s, input logic x, input logic [5:0] v,
                        input logic [31:0] base, input logic [31:0] stride,
                        input logic [63:0] d, output int lat, output int span);
    int n;
    cur_base   = base;
    cur_stride = stride;
    n = 0;
    @(posedge clk);
    #1;
    while (!rdy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    req = 1'b1; we_in = w; sz_in = s; sx_in = x; vl_in = v; dat_in = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
      if (done && lat < 0) lat = n;
    end while (!rdy && n < 3000);
    span = n;
    check("op_completes", rdy, 1'b1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] ea;
    logic [7:0]  sel;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t  tbl[10];
  done_t r;
  int    lat, span, c0, vle, nb;
  logic  w, x;
  logic [1:0]  s;
  logic [5:0]  v;
  logic [31:0] base, stride, a;
  logic [63:0] d, ev;
  logic [63:0] exp_res[$];

  initial begin
    tbl[0] = '{1'b0, 2'd0, 1'b1, 32'h1003, 8'h08, 64'hFFFF_FFFF_FFFF_FF80, 3};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 32'h1083, 8'h08, 64'h0000_0000_0000_0083, 3};
    tbl[2] = '{1'b0, 2'd1, 1'b1, 32'h10F0, 8'h03, 64'hFFFF_FFFF_FFFF_F1F0, 3};
    tbl[3] = '{1'b0, 2'd1, 1'b0, 32'h1017, 8'h80, 64'h0000_0000_0000_1817, 4};
    tbl[4] = '{1'b0, 2'd2, 1'b1, 32'h1014, 8'hF0, 64'h0000_0000_1716_1514, 3};
    tbl[5] = '{1'b0, 2'd2, 1'b1, 32'h10C6, 8'hC0, 64'hFFFF_FFFF_C9C8_C7C6, 4};
    tbl[6] = '{1'b0, 2'd3, 1'b0, 32'h1020, 8'hFF, 64'h2726_2524_2322_2120, 3};
    tbl[7] = '{1'b0, 2'd3, 1'b1, 32'h103B, 8'hF8, 64'h4241_403F_3E3D_3C3B, 4};
    tbl[8] = '{1'b0, 2'd2, 1'b0, 32'h10FC, 8'hF0, 64'h0000_0000_FFFE_FDFC, 3};
    tbl[9] = '{1'b0, 2'd0, 1'b1, 32'h1045, 8'h20, 64'h0000_0000_0000_0045, 3};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    ref_mem[3] = 8'h80;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdy", rdy, 1'b1);
    check("rst_outs", {cyc, stb, bwe, done, last, err}, 6'd0);
    check("rst_bus", {sel, adr, bdout, step, res}, '0);
    rst = 1'b0;
    load_mem();

    // Directed scalar loads, zero wait states
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].we, tbl[i].sz, tbl[i].sx, 6'd1, tbl[i].ea, 32'd0, 64'd0, lat, span);
      check($sformatf("tbl%0d_count", i), dq.size(), 1);
      if (dq.size() > 0) begin
        r = dq.pop_front();
        check($sformatf("tbl%0d_res", i), r.res, tbl[i].res);
        check($sformatf("tbl%0d_last_err", i), {r.last, r.err}, 2'b10);
      end
      check($sformatf("tbl%0d_sel", i), first_sel, tbl[i].sel);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      dq.delete();
    end

    // Split octa store
    run_op(1'b1, 2'd3, 1'b0, 6'd1, 32'h2005, 32'd0, 64'h1122_3344_5566_7788, lat, span);
    check("st_adr1", first_adr, 32'h2000);
    check("st_sel1", first_sel, 8'hE0);
    check("st_dat1", first_dat[63:40], 24'h667788);
    check("st_adr2", sec_adr, 32'h2008);
    check("st_sel2", sec_sel, 8'h1F);
    check("st_dat2", sec_dat[39:0], 40'h11_2233_4455);
    check("st_count", dq.size(), 1);
    if (dq.size() > 0) begin
      r = dq.pop_front();
      check("st_res_last_err", {r.res, r.last, r.err}, {64'd0, 2'b10});
    end
    for (int k = 0; k < 8; k++) ev[8*k +: 8] = mem[5 + k];
    check("st_mem", ev, 64'h1122_3344_5566_7788);
    dq.delete();

    // Vector byte load, vl=4
    wait_max = 1;
    run_op(1'b0, 2'd0, 1'b0, 6'd4, 32'h1050, 32'd1, 64'd0, lat, span);
    check("vec_count", dq.size(), 4);
    for (int e = 0; e < 4; e++) begin
      if (dq.size() > 0) begin
        r = dq.pop_front();
        check($sformatf("vec_e%0d", e), {r.res, r.last, r.err, r.step},
              {64'(8'h50 + 8'(e)), (e == 3), 1'b0, 6'(e)});
      end
    end
    dq.delete();

    // Timeout: no ack at all
    slave_silent = 1'b1;
    c0 = cyc_total;
    run_op(1'b0, 2'd3, 1'b0, 6'd2, 32'h4000, 32'd8, 64'd0, lat, span);
    check("tmo_cyc_cycles", cyc_total - c0, TMO);
    check("tmo_count", dq.size(), 1);
    if (dq.size() > 0) begin
      r = dq.pop_front();
      check("tmo_done", {r.res, r.last, r.err, r.cyc}, {64'd0, 3'b110});
    end
    check("tmo_rdy_next", span, lat + 1);
    dq.delete();
    slave_silent = 1'b0;

    // berr together with ack on the second cycle of a split; remaining elements dropped
    berr_at = ack_total + 2;
    run_op(1'b0, 2'd3, 1'b0, 6'd3, 32'h4003, 32'd8, 64'd0, lat, span);
    check("berr_count", dq.size(), 1);
    if (dq.size() > 0) begin
      r = dq.pop_front();
      check("berr_done", {r.res, r.last, r.err, r.step}, {64'd0, 2'b11, 6'd0});
    end
    dq.delete();
    berr_at = 0;

    // Asynchronous reset in the middle of ACC1
    slave_silent = 1'b1;
    cur_base = 32'h5000;
    @(posedge clk);
    #1 req = 1'b1; we_in = 1'b0; sz_in = 2'd3; vl_in = 6'd1;
    @(posedge clk);
    #1 req = 1'b0;
    nb = 0;
    while (!cyc && nb < 10) begin
      @(negedge clk);
      nb++;
    end
    check("rst_mid_cyc_before", cyc, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_bus", {cyc, stb}, 2'b00);
    check("rst_mid_idle", {rdy, done}, 2'b10);
    @(negedge clk);
    rst = 1'b0;
    slave_silent = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_done", dq.size(), 0);
    dq.delete();

    // Randomized ops against the byte-level memory model
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    load_mem();
    wait_max = 2;
    for (int t = 0; t < 60; t++) begin
      w      = 1'($urandom_range(1, 0));
      s      = 2'($urandom_range(3, 0));
      x      = 1'($urandom_range(1, 0));
      v      = 6'($urandom_range(5, 0));
      base   = 32'h3000 + 32'($urandom_range(255, 0));
      stride = 32'($urandom_range(12, 0));
      d      = {$urandom, $urandom};
      vle    = (v == 0) ? 1 : int'(v);
      nb     = 1 << s;
      exp_res.delete();
      for (int e = 0; e < vle; e++) begin
        a  = base + stride * 32'(e);
        ev = 64'd0;
        for (int k = 0; k < nb; k++) begin
          if (w) ref_mem[8'(a + 32'(k))] = d[8*k +: 8];
          else ev[8*k +: 8] = ref_mem[8'(a + 32'(k))];
        end
        if (!w && x && nb < 8 && ev[8*nb-1]) ev = ev | ~((64'd1 << (8*nb)) - 64'd1);
        exp_res.push_back(ev);
      end
      run_op(w, s, x, v, base, stride, d, lat, span);
      check($sformatf("rnd%0d_count", t), dq.size(), vle);
      for (int e = 0; e < vle; e++) begin
        if (dq.size() > 0) begin
          r = dq.pop_front();
          check($sformatf("rnd%0d_e%0d", t, e), {r.res, r.last, r.err, r.step},
                {exp_res[e], (e == vle - 1), 1'b0, 6'(e)});
        end
      end
      nb = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nb++;
      check($sformatf("rnd%0d_mem", t), nb, 0);
      dq.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
